prp_job_scheduler: RTL and testbench

//  Shares one PRP systolic array (batch PRP forward/inverse engine) among NUM_REQ requesters.

---
 rtl/prp_job_scheduler.sv | 109 ++++++++++
 tb/tb_prp_job_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prp_job_scheduler.sv
// prp_job_scheduler: round-robin arbiter, parameter checker and watchdog for one shared PRP array
module prp_job_scheduler #(
  parameter int WIDTH      = 64,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int MAX_ROUNDS = 128,
  parameter int TIMEOUT    = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_domain,
  input  logic [NUM_REQ*8-1:0]     req_rounds,
  input  logic [NUM_REQ-1:0]       req_dir,
  output logic                     arr_start,
  output logic [WIDTH-1:0]         arr_domain,
  output logic [7:0]               arr_num_rounds,
  output logic                     arr_direction,
  input  logic                     arr_done,
  input  logic                     arr_busy,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [1:0]               rsp_status,
  output logic                     fault,
  input  logic                     fault_clr,
  output logic [15:0]              jobs_done
);
  typedef enum logic [2:0] {IDLE, ISSUE, RUN, RESP, FAULT} state_t;
  localparam int WD_W = $clog2(TIMEOUT);
  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, id, grant;
  logic [ID_W:0] cand;
  logic [WD_W-1:0] wdog;
  logic [WIDTH-1:0] sel_dom;
  logic [7:0] sel_rnd;
  logic any_valid, hs, bad, wd_exp;
  // Highest offset is visited first so the requester closest to rr_ptr wins.
  always_comb begin
    grant = rr_ptr;
    any_valid = 1'b0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (req_valid[cand[ID_W-1:0]]) begin
        grant = cand[ID_W-1:0];
        any_valid = 1'b1;
      end
    end
  end
  assign req_ready = (rst_n && state == IDLE && !arr_busy && !fault && any_valid) ?
                     NUM_REQ'(1) << grant : '0;
  assign hs = |(req_valid & req_ready);
  assign sel_dom = req_domain[grant*WIDTH +: WIDTH];
  assign sel_rnd = req_rounds[grant*8 +: 8];
  assign bad = sel_rnd == 8'd0 || int'(sel_rnd) > MAX_ROUNDS || sel_dom < WIDTH'(2);
  assign wd_exp = wdog == WD_W'(TIMEOUT - 1);
  assign arr_start = state == ISSUE;
  assign rsp_valid = state == RESP;
  assign rsp_id = id;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = hs ? (bad ? RESP : ISSUE) : IDLE;
      ISSUE:   state_nx = RUN;
      RUN:     state_nx = (arr_done || wd_exp) ? RESP : RUN;
      RESP:    state_nx = rsp_ready ? (fault ? FAULT : IDLE) : RESP;
      FAULT:   state_nx = fault_clr ? IDLE : FAULT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      id <= '0;
      arr_domain <= '0;
      arr_num_rounds <= '0;
      arr_direction <= 1'b0;
      wdog <= '0;
      rsp_status <= 2'd0;
      fault <= 1'b0;
      jobs_done <= '0;
    end else begin
      state <= state_nx;
      wdog <= state == RUN ? wdog + 1'b1 : '0;
      if (state == IDLE && hs) begin
        id <= grant;
        arr_domain <= sel_dom;
        arr_num_rounds <= sel_rnd;
        arr_direction <= req_dir[grant];
        if (bad) rsp_status <= 2'd1;
      end
      // Done wins over an expiring watchdog in the same cycle.
      if (state == RUN && arr_done) rsp_status <= 2'd0;
      else if (state == RUN && wd_exp) begin
        rsp_status <= 2'd2;
        fault <= 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rr_ptr <= (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
        if (rsp_status == 2'd0) jobs_done <= jobs_done + 16'd1;
      end
      if (state == FAULT && fault_clr) fault <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prp_job_scheduler.sv
// tb_prp_job_scheduler: directed scenarios plus random traffic checked every cycle against a job-level model
module tb_prp_job_scheduler;
  localparam int W = 64, N = 4, ID_W = 2, MAXR = 128, TIMEOUT = 32;
  localparam int P_IDLE = 0, P_ISSUE = 1, P_RUN = 2, P_RESP = 3, P_FAULT = 4;
  logic clk = 0, rst_n = 0;
  logic [N-1:0] req_valid = '0, req_ready, req_dir = '0;
  logic [N*W-1:0] req_domain = '0;
  logic [N*8-1:0] req_rounds = '0;
  logic arr_start, arr_direction, arr_done = 0, arr_busy = 0, rsp_valid, rsp_ready = 0, fault, fault_clr = 0;
  logic [W-1:0] arr_domain;
  logic [7:0] arr_num_rounds;
  logic [ID_W-1:0] rsp_id;
  logic [1:0] rsp_status;
  logic [15:0] jobs_done;
  int errors = 0, checks = 0;
  prp_job_scheduler #(.WIDTH(W), .NUM_REQ(N), .ID_W(ID_W), .MAX_ROUNDS(MAXR), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_domain(req_domain),
    .req_rounds(req_rounds), .req_dir(req_dir), .arr_start(arr_start), .arr_domain(arr_domain),
    .arr_num_rounds(arr_num_rounds), .arr_direction(arr_direction), .arr_done(arr_done), .arr_busy(arr_busy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_status(rsp_status), .fault(fault),
    .fault_clr(fault_clr), .jobs_done(jobs_done));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Job-level model: which phase the single job is in and how many RUN cycles it has had.
  int m_ph, m_rr, m_id, m_run;
  logic [W-1:0] m_dom;
  logic [7:0] m_rnd;
  logic m_dir, m_fault;
  logic [1:0] m_st;
  logic [15:0] m_jobs;
  function automatic int gsel();
    for (int k = 0; k < N; k++) if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction
  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r = '0;
    if (rst_n && m_ph == P_IDLE && !arr_busy && !m_fault && gsel() >= 0) r[gsel()] = 1'b1;
    return r;
  endfunction
  function automatic logic bad_job();
    int r = int'(req_rounds[gsel()*8 +: 8]);
    return r == 0 || r > MAXR || req_domain[gsel()*W +: W] < 2;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= P_IDLE; m_rr <= 0; m_id <= 0; m_run <= 0; m_dom <= '0; m_rnd <= '0;
      m_dir <= 0; m_fault <= 0; m_st <= 0; m_jobs <= '0;
    end else if (m_ph == P_IDLE) begin
      if (exp_ready() != 0) begin
        m_id <= gsel(); m_dom <= req_domain[gsel()*W +: W]; m_rnd <= req_rounds[gsel()*8 +: 8];
        m_dir <= req_dir[gsel()];
        m_ph <= bad_job() ? P_RESP : P_ISSUE;
        if (bad_job()) m_st <= 2'd1;
      end
    end else if (m_ph == P_ISSUE) begin
      m_ph <= P_RUN; m_run <= 1;
    end else if (m_ph == P_RUN) begin
      if (arr_done) begin m_ph <= P_RESP; m_st <= 2'd0; end
      else if (m_run == TIMEOUT) begin m_ph <= P_RESP; m_st <= 2'd2; m_fault <= 1; end
      else m_run <= m_run + 1;
    end else if (m_ph == P_RESP) begin
      if (rsp_ready) begin
        m_rr <= (m_id + 1) % N;
        if (m_st == 0) m_jobs <= m_jobs + 16'd1;
        m_ph <= m_fault ? P_FAULT : P_IDLE;
      end
    end else if (fault_clr) begin
      m_fault <= 0; m_ph <= P_IDLE;
    end
  end
  int cyc_n = 0, n_start = 0, n_rsp = 0, t_start = 0, t_rsp = 0;
  logic prev_rv = 0;
  int grants[$], rsps[$];
  always @(negedge clk) begin
    cyc_n++;
    chk("req_ready", req_ready, exp_ready());
    chk("arr_start", arr_start, m_ph == P_ISSUE);
    chk("arr_domain", arr_domain, m_dom);
    chk("arr_num_rounds", arr_num_rounds, m_rnd);
    chk("arr_direction", arr_direction, m_dir);
    chk("rsp_valid", rsp_valid, m_ph == P_RESP);
    chk("rsp_id", rsp_id, m_id);
    chk("rsp_status", rsp_status, m_st);
    chk("fault", fault, m_fault);
    chk("jobs_done", jobs_done, m_jobs);
    if (arr_start) begin n_start++; t_start = cyc_n; end
    if (rsp_valid && !prev_rv) t_rsp = cyc_n;
    prev_rv = rsp_valid;
    for (int r = 0; r < N; r++) if (req_valid[r] && req_ready[r]) grants.push_back(r);
    if (rsp_valid && rsp_ready) begin rsps.push_back(int'(rsp_id)); n_rsp++; end
  end
  // Array stand-in: directed mode answers done_dly cycles after the start pulse (never if -1).
  int since = 0, done_dly = -1;
  bit active = 0, rand_arr = 0, quiet = 0;
  always @(negedge clk) begin
    if (arr_start) begin active = 1; since = 0; end
    else if (active) begin
      if (since == done_dly || rsp_valid) active = 0;
      else since++;
    end
  end
  always @(posedge clk) begin
    #1;
    if (rand_arr) begin
      arr_done = !quiet && ($urandom % 8 == 0);
      arr_busy = ($urandom % 4 == 0);
    end else begin
      arr_done = active && (since + 1 == done_dly);
      arr_busy = active;
    end
  end
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_rsp(input int lim);
    int k = 0;
    while (!rsp_valid && k < lim) begin cyc(); k++; end
    chk("rsp_wait", k < lim, 1);
    @(negedge clk);
    #1;
  endtask
  task automatic accept();
    rsp_ready = 1; cyc(); rsp_ready = 0;
  endtask
  task automatic set_slot(input int r, input logic [63:0] d, input int rn, input logic dr);
    req_domain[r*W +: W] = d; req_rounds[r*8 +: 8] = 8'(rn); req_dir[r] = dr;
  endtask
  logic [63:0] bp_dom [4] = '{64'd1000, 64'd1000, 64'd1, 64'd2};
  int bp_rnd [4] = '{0, 129, 8, 128};
  int bp_st [4] = '{1, 1, 1, 0};
  int exp_g [5] = '{0, 1, 2, 3, 0};
  int n0, k;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    req_valid = '1;
    cyc(3);
    chk("reset_ready", req_ready, 0);
    chk("reset_outs", {arr_start, arr_direction, rsp_valid, fault, rsp_status, rsp_id}, 0);
    chk("reset_latch", arr_domain | 64'(arr_num_rounds) | 64'(jobs_done), 0);
    req_valid = '0; rst_n = 1; cyc(2);
    // Round-robin with every requester asking continuously.
    for (int r = 0; r < N; r++) set_slot(r, 64'(100 + r), 4, r[0]);
    done_dly = 3; rsp_ready = 1; req_valid = '1; k = 0;
    while (grants.size() < 5 && k < 300) begin cyc(); k++; end
    req_valid = '0; cyc(20); rsp_ready = 0;
    chk("rr_count", grants.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", grants.size() > i ? grants[i] : 99, exp_g[i]);
      chk("rr_rsp_id", rsps.size() > i ? rsps[i] : 99, exp_g[i]);
    end
    chk("rr_nrsp", n_rsp, 5);
    chk("rr_jobs", jobs_done, 5);
    // Single forward job with a 20-cycle array run.
    n_start = 0; set_slot(0, 64'd1000, 8, 1); done_dly = 20; req_valid = 4'b0001;
    cyc(); req_valid = '0;
    wait_rsp(60);
    chk("t1_start_cnt", n_start, 1);
    chk("t1_dom", arr_domain, 1000);
    chk("t1_rounds", arr_num_rounds, 8);
    chk("t1_dir", arr_direction, 1);
    chk("t1_id", rsp_id, 0);
    chk("t1_status", rsp_status, 0);
    chk("t1_latency", t_rsp - t_start, 21);
    accept();
    chk("t1_jobs", jobs_done, 6);
    // Parameter validation, ending with the largest legal job.
    n0 = n_start;
    for (int i = 0; i < 4; i++) begin
      set_slot(0, bp_dom[i], bp_rnd[i], 0); done_dly = 2; req_valid = 4'b0001;
      cyc(); req_valid = '0;
      wait_rsp(60);
      chk("bp_status", rsp_status, bp_st[i]);
      chk("bp_id", rsp_id, 0);
      accept();
      chk("bp_starts", n_start - n0, i == 3);
      chk("bp_jobs", jobs_done, 6 + (i == 3));
    end
    // Watchdog expiry, fault lockout, recovery.
    set_slot(0, 64'd500, 5, 0); done_dly = -1; req_valid = 4'b0001;
    cyc(); req_valid = '0;
    wait_rsp(TIMEOUT + 10);
    chk("to_status", rsp_status, 2);
    chk("to_fault", fault, 1);
    chk("to_latency", t_rsp - t_start, TIMEOUT + 1);
    req_valid = '1; accept(); cyc(5);
    chk("to_ready_blocked", req_ready, 0);
    chk("to_fault_sticky", fault, 1);
    chk("to_jobs", jobs_done, 7);
    fault_clr = 1; cyc(); fault_clr = 0;
    chk("to_fault_clr", fault, 0);
    chk("to_regrant", req_ready, 4'b0010);
    done_dly = 4; cyc(); req_valid = '0;
    wait_rsp(60);
    chk("to_next_id", rsp_id, 1);
    chk("to_next_status", rsp_status, 0);
    accept();
    // Response held back while everyone keeps requesting.
    done_dly = 3; req_valid = '1; cyc();
    wait_rsp(60);
    n0 = n_start;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_id", rsp_id, 2);
      chk("hold_status", rsp_status, 0);
      chk("hold_ready", req_ready, 0);
      cyc();
    end
    chk("hold_nostart", n_start, n0);
    req_valid = '0; accept();
    chk("hold_jobs", jobs_done, 9);
    // Asynchronous reset in the middle of a run.
    set_slot(1, 64'd777, 9, 1); done_dly = 8; req_valid = 4'b0010;
    cyc(); req_valid = '0; cyc(3);
    rst_n = 0; #1;
    chk("rst_outs", {arr_start, arr_direction, rsp_valid, fault, rsp_status, rsp_id, req_ready}, 0);
    chk("rst_latch", arr_domain | 64'(arr_num_rounds) | 64'(jobs_done), 0);
    cyc(); rst_n = 1; n0 = n_rsp; cyc(10);
    chk("rst_no_rsp", n_rsp, n0);
    chk("rst_rsp_valid", rsp_valid, 0);
    grants.delete(); done_dly = 2; req_valid = '1; cyc(); req_valid = '0;
    chk("rst_first_grant", grants.size() > 0 ? grants[0] : 99, 0);
    wait_rsp(60); accept();
    // Random traffic against the model.
    rand_arr = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 256 == 0) quiet = ($urandom % 3 == 0);
      rst_n = ($urandom % 400 != 0);
      req_valid = N'($urandom); req_dir = N'($urandom);
      for (int r = 0; r < N; r++) begin
        k = $urandom % 8;
        req_domain[r*W +: W] = ($urandom % 4 == 0) ? 64'($urandom % 4) : {$urandom, $urandom};
        req_rounds[r*8 +: 8] = k == 0 ? 8'd0 : k == 1 ? 8'(127 + $urandom % 3) : 8'($urandom);
      end
      rsp_ready = ($urandom % 2 == 1); fault_clr = ($urandom % 8 == 0);
      cyc();
    end
    rand_arr = 0; active = 0; done_dly = -1; rst_n = 1; req_valid = '0; rsp_ready = 1; fault_clr = 1;
    cyc(TIMEOUT + 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
